// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, grant owners and FSM states.
package memory_arbiter_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_DATA,
      OWN_I0,
      OWN_I1
   } mem_owner_t;

   typedef enum logic {
      ARB_IDLE,
      ARB_SERVE
   } arb_state_t;

   localparam int TCNT_W = 10;

   function automatic mem_owner_t instrOwner(input logic idx);
      return idx ? OWN_I1 : OWN_I0;
   endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester and RAM side signals of the memory arbiter; the arbiter is the slave,
// the bus controller / cores / RAM side is the master.
interface memory_arbiter_if;
   import memory_arbiter_pkg::*;

   logic            dREN;
   logic            dWEN;
   word_t           daddr;
   word_t           dstore;
   word_t           dload;
   logic            dwait;
   logic [1:0]      iREN;
   word_t [1:0]     iaddr;
   word_t           iload;
   logic [1:0]      iwait;
   logic            ramREN;
   logic            ramWEN;
   word_t           ramaddr;
   word_t           ramstore;
   word_t           ramload;
   ramstate_t       ramstate;
   logic            err;

   modport slave (
      input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
      output dload, dwait, iload, iwait, ramREN, ramWEN, ramaddr, ramstore, err
   );

   modport master (
      output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
      input  dload, dwait, iload, iwait, ramREN, ramWEN, ramaddr, ramstore, err
   );

endinterface

// File: rtl/memory_arbiter_rr_arbiter2.sv
// Two-way round-robin pointer for the fetch ports: prefers core rr, falls back to the other.
module memory_arbiter_rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   input  logic       served_i,
   output logic       grant_o
);
   logic rr_q, rr_d;

   // After serving core k the pointer moves to the other core.
   always_comb begin
      rr_d = rr_q;
      if (advance_i) begin
         rr_d = ~served_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end

   assign grant_o = req_i[rr_q] ? rr_q : ~rr_q;

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: the data port wins unless it has used DATA_STREAK grants in a row
// while a fetch waits; fetch ports alternate round-robin. RAM is driven live from the owner.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int DATA_STREAK = 4,
   parameter int TIMEOUT     = 1023
) (
   input logic             CLK,
   input logic             RST,
   memory_arbiter_if.slave bus
);
   localparam int SW = $clog2(DATA_STREAK + 1);

   arb_state_t        state_q, state_d;
   mem_owner_t        owner_q, owner_d;
   logic [SW-1:0]     streak_q, streak_d;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
   logic              err_q, err_d;

   logic dataPending, instrPending, serving, ownerIsData, curIdx;
   logic ownerLive, ramDone, complete, rrGrant;

   assign dataPending  = bus.dREN | bus.dWEN;
   assign instrPending = |bus.iREN;
   assign serving      = (state_q == ARB_SERVE);
   assign ownerIsData  = (owner_q == OWN_DATA);
   assign curIdx       = (owner_q == OWN_I1);
   assign ownerLive    = ownerIsData ? dataPending : bus.iREN[curIdx];
   assign ramDone      = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
   assign complete     = serving & ownerLive & ramDone;

   memory_arbiter_rr_arbiter2 u_rr (
      .clk       (CLK),
      .rst       (RST),
      .req_i     (bus.iREN),
      .advance_i (complete & ~ownerIsData),
      .served_i  (curIdx),
      .grant_o   (rrGrant)
   );

   // Grant in IDLE; in SERVE finish on ACCESS/ERROR, abort on dropped request or timeout.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      streak_d = streak_q;
      tcnt_d   = tcnt_q;
      err_d    = err_q;
      case (state_q)
         ARB_IDLE: begin
            tcnt_d = '0;
            if (dataPending && ((streak_q < SW'(DATA_STREAK)) || !instrPending)) begin
               state_d = ARB_SERVE;
               owner_d = OWN_DATA;
            end else if (instrPending) begin
               state_d = ARB_SERVE;
               owner_d = instrOwner(rrGrant);
            end else begin
               owner_d  = OWN_NONE;
               streak_d = '0;
            end
         end
         ARB_SERVE: begin
            if (!ownerLive) begin
               state_d = ARB_IDLE;
               owner_d = OWN_NONE;
            end else if (ramDone) begin
               state_d = ARB_IDLE;
               owner_d = OWN_NONE;
               if (bus.ramstate == ERROR) begin
                  err_d = 1'b1;
               end
               if (!ownerIsData) begin
                  streak_d = '0;
               end else if (streak_q < SW'(DATA_STREAK)) begin
                  streak_d = streak_q + 1'b1;
               end
            end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
               state_d = ARB_IDLE;
               owner_d = OWN_NONE;
               err_d   = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ARB_IDLE;
         owner_q  <= OWN_NONE;
         streak_q <= '0;
         tcnt_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         streak_q <= streak_d;
         tcnt_q   <= tcnt_d;
         err_q    <= err_d;
      end
   end

   // A simultaneous read and write from the data port becomes a write only.
   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      if (serving) begin
         if (ownerIsData) begin
            bus.ramWEN   = bus.dWEN;
            bus.ramREN   = bus.dREN & ~bus.dWEN;
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
         end else begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.iaddr[curIdx];
         end
      end
   end

   always_comb begin
      bus.dwait = ~(complete & ownerIsData);
      bus.dload = (complete & ownerIsData) ? bus.ramload : '0;
      bus.iwait = 2'b11;
      bus.iload = '0;
      if (complete && !ownerIsData) begin
         bus.iwait[curIdx] = 1'b0;
         bus.iload         = bus.ramload;
      end
   end

   assign bus.err = err_q;

endmodule
